tc_event_monitor: RTL and testbench
===================================

# tc_event_monitor

Downstream consumer of the cascaded counter chain's terminal-count output. Detects each rising edge of the chain's final terminal-count signal, timestamps it with a free-running cycle timer, computes the interval since the previous edge, and queues (timestamp, period) records in a small FIFO. A host reads the records over a valid/ready handshake. Running event and drop counters support chain characterisation on the SmartFusion2 board.

## Interface
- TS_WIDTH, 32: width of the free-running timer, timestamps and periods.
- DEPTH, 4: FIFO entries; power of two, 2..16.
- CNT_WIDTH, 16: width of the total-event counter.

- clk  in  1  system clock; everything is in this domain.
- reset  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous soft clear, active-high.
- tc_in  in  1  final terminal-count level from the counter chain; synchronous to clk.
- evt_valid  out  1  FIFO head record available.
- evt_ready  in  1  consumer accepts the head record.
- evt_ts  out  TS_WIDTH  timer value at the edge cycle.
- evt_period  out  TS_WIDTH  cycles since the previous accepted edge; 0 for the first edge after reset or clear.
- evt_first  out  1  head record is the first edge after reset or clear.
- evt_count  out  CNT_WIDTH  total rising edges detected, whether queued or dropped.
- drop_count  out  8  edges dropped because the FIFO was full; saturates at 255.
- overflow  out  1  sticky; set on any drop.

## Operation
- Edge detect:
  - tc_d is a register of tc_in.
  - edge = tc_in & ~tc_d, evaluated combinationally in the cycle tc_in first reads high.
  - A long-high tc_in produces exactly one edge.
- Timer:
  - Free-running, increments every cycle, wraps from 2^TS_WIDTH-1 to 0.
  - clear does not affect the timer.
- Capture on an edge cycle:
  - Record = {timer, timer − last_ts mod 2^TS_WIDTH, first}.
  - Wrap-around is handled by modular subtraction.
  - If the FIFO is not full at the start of the cycle: push the record, set last_ts = timer, clear the first flag.
  - If the FIFO is full at the start of the cycle: drop the record, even when a pop occurs in the same cycle. Set overflow, increment drop_count (saturating), leave last_ts unchanged.
  - evt_count increments on every edge, queued or dropped, and wraps.
- FIFO:
  - Circular buffer with read and write pointers plus an occupancy counter (0..DEPTH).
  - Pop = evt_valid & evt_ready.
  - Push and pop in the same cycle with 0 < occupancy < DEPTH leaves occupancy unchanged.
  - Push into an empty FIFO: the record appears at the head the next cycle.
- Handshake:
  - evt_valid = (occupancy != 0).
  - evt_ts, evt_period and evt_first are held stable while evt_valid & ~evt_ready.
  - evt_ready with evt_valid low has no effect.
- clear (synchronous):
  - Empties the FIFO and zeroes evt_count, drop_count and overflow.
  - Re-arms the first flag and sets last_ts to 0.
  - An edge in the same cycle as clear is discarded and not counted.
  - tc_d still updates during clear.
- Reset (asynchronous, reset = 0):
  - All outputs and state go to 0: evt_valid 0, evt_ts 0, evt_period 0, evt_first 0, evt_count 0, drop_count 0, overflow 0, timer 0, tc_d 0.
  - First flag is armed.
  - Mid-operation reset discards queued records immediately.
- No state machine beyond the FIFO occupancy. The datapath states are EMPTY (occupancy 0), PARTIAL and FULL (occupancy DEPTH), moving by push/pop as above.

## Timing
- Edge-to-evt_valid latency: 1 cycle when the FIFO is empty.
- Timestamp latch: timer value in the cycle tc_in is first high. A tc_in rising at timer = T yields evt_ts = T.
- evt_count, drop_count and overflow update 1 cycle after the edge cycle.
- Throughput: one record per cycle in and out.
- Minimum edge spacing is 2 cycles, because tc_in must return low for at least one cycle between edges.
- Reset release: the timer is 0 in the first cycle reset reads high, and counts from there.

## Test plan
- Reset release, tc_in high at timer = 10 for 5 cycles, evt_ready = 1:
  - Exactly one record: evt_ts = 10, evt_period = 0, evt_first = 1, evt_count = 1.
  - evt_valid is high for one cycle.
- Edges at timer = 10, 110 and 310, evt_ready = 1:
  - Periods 0, 100, 200.
  - evt_first is high only on the first record.
- evt_ready = 0, DEPTH = 4, six edges:
  - evt_valid high, head stable at the first record.
  - After the burst: drop_count = 2, overflow = 1, evt_count = 6.
  - Draining yields exactly 4 records, in order.
- TS_WIDTH = 8, edges at timer = 250 and 4 (after wrap):
  - Second record: evt_ts = 4, evt_period = 10.
- FIFO full with evt_ready = 1 and an edge in the same cycle:
  - Edge dropped, occupancy becomes 3.
- Assert clear in an edge cycle with 2 records queued, then an edge at timer = 50:
  - After clear: evt_valid = 0, counters 0.
  - Next record: evt_first = 1, evt_period = 0.
- Drive reset low mid-drain:
  - Outputs go to 0 asynchronously, before the next clk edge.

Source files
------------

// File: rtl/tc_event_monitor_if.sv
// ---------------------------------------------------------------------------
// tc_event_monitor_if
// Record handshake between the terminal-count event monitor and its host.
//   evt_valid  : head record available (driven by the monitor)
//   evt_ready  : host accepts the head record (driven by the host)
//   evt_ts     : timer value captured on the edge cycle
//   evt_period : cycles since the previous queued edge (0 for the first)
//   evt_first  : record is the first edge after reset or clear
// ---------------------------------------------------------------------------
interface tc_event_monitor_if #(
  parameter int TS_WIDTH = 32
);
  logic                evt_valid;
  logic                evt_ready;
  logic [TS_WIDTH-1:0] evt_ts;
  logic [TS_WIDTH-1:0] evt_period;
  logic                evt_first;

  modport master (
    output evt_valid, evt_ts, evt_period, evt_first,
    input  evt_ready
  );

  modport slave (
    input  evt_valid, evt_ts, evt_period, evt_first,
    output evt_ready
  );
endinterface

// File: rtl/tc_event_monitor.sv
// ---------------------------------------------------------------------------
// tc_event_monitor
// Detects rising edges of the counter chain's terminal-count level, stamps
// them with a free-running timer, computes the interval since the previous
// queued edge and buffers (timestamp, period, first) records in a FIFO that a
// host drains over a valid/ready handshake.
//
// Ports
//   clk_i        : system clock
//   rst_ni       : asynchronous active-low reset
//   clear_i      : synchronous soft clear (FIFO, counters, first flag)
//   tc_i         : terminal-count level, synchronous to clk_i
//   evt_if       : record handshake (master side)
//   evt_count_o  : rising edges detected, queued or dropped (wraps)
//   drop_count_o : edges dropped on a full FIFO (saturates at 255)
//   overflow_o   : sticky drop indicator
// ---------------------------------------------------------------------------
module tc_event_monitor #(
  parameter int TS_WIDTH  = 32,
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  tc_i,
  tc_event_monitor_if.master    evt_if,
  output logic [CNT_WIDTH-1:0]  evt_count_o,
  output logic [7:0]            drop_count_o,
  output logic                  overflow_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);

  // State
  logic                 tc_q;
  logic [TS_WIDTH-1:0]  timer_q,      timer_d;
  logic [TS_WIDTH-1:0]  last_ts_q,    last_ts_d;
  logic                 first_q,      first_d;
  logic [PTR_W-1:0]     wr_ptr_q,     wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q,     rd_ptr_d;
  logic [OCC_W-1:0]     occ_q,        occ_d;
  logic [CNT_WIDTH-1:0] evt_count_q,  evt_count_d;
  logic [7:0]           drop_count_q, drop_count_d;
  logic                 overflow_q,   overflow_d;

  // Record storage (no reset; contents are only visible while occupied)
  logic [TS_WIDTH-1:0]  ts_mem     [DEPTH];
  logic [TS_WIDTH-1:0]  period_mem [DEPTH];
  logic                 first_mem  [DEPTH];

  logic                 tc_edge;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 push;
  logic                 pop;
  logic                 drop;
  logic [TS_WIDTH-1:0]  period_new;

  assign tc_edge    = tc_i & ~tc_q;
  assign fifo_full  = (occ_q == OCC_W'(DEPTH));
  assign fifo_empty = (occ_q == '0);
  assign pop        = ~fifo_empty & evt_if.evt_ready;
  // Fullness is judged on the occupancy at the start of the cycle, so a
  // simultaneous pop does not rescue an edge arriving on a full FIFO.
  assign push       = tc_edge & ~fifo_full & ~clear_i;
  assign drop       = tc_edge &  fifo_full & ~clear_i;
  // Modular subtraction handles timer wrap; the first record reports 0.
  assign period_new = first_q ? '0 : (timer_q - last_ts_q);

  always_comb begin
    timer_d      = timer_q + TS_WIDTH'(1);
    last_ts_d    = last_ts_q;
    first_d      = first_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    occ_d        = occ_q;
    evt_count_d  = evt_count_q;
    drop_count_d = drop_count_q;
    overflow_d   = overflow_q;

    if (clear_i) begin
      // An edge coinciding with clear is neither queued nor counted.
      last_ts_d    = '0;
      first_d      = 1'b1;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      occ_d        = '0;
      evt_count_d  = '0;
      drop_count_d = '0;
      overflow_d   = 1'b0;
    end else begin
      if (tc_edge) begin
        evt_count_d = evt_count_q + CNT_WIDTH'(1);
      end
      if (push) begin
        wr_ptr_d  = wr_ptr_q + PTR_W'(1);
        last_ts_d = timer_q;
        first_d   = 1'b0;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (drop) begin
        overflow_d = 1'b1;
        if (drop_count_q != 8'hFF) begin
          drop_count_d = drop_count_q + 8'd1;
        end
      end
      case ({push, pop})
        2'b10:   occ_d = occ_q + OCC_W'(1);
        2'b01:   occ_d = occ_q - OCC_W'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tc_q         <= 1'b0;
      timer_q      <= '0;
      last_ts_q    <= '0;
      first_q      <= 1'b1;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      occ_q        <= '0;
      evt_count_q  <= '0;
      drop_count_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      tc_q         <= tc_i;
      timer_q      <= timer_d;
      last_ts_q    <= last_ts_d;
      first_q      <= first_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      occ_q        <= occ_d;
      evt_count_q  <= evt_count_d;
      drop_count_q <= drop_count_d;
      overflow_q   <= overflow_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      ts_mem[wr_ptr_q]     <= timer_q;
      period_mem[wr_ptr_q] <= period_new;
      first_mem[wr_ptr_q]  <= first_q;
    end
  end

  // Head fields are forced to 0 while empty so that an asynchronous reset
  // zeroes them immediately, independent of the un-reset storage.
  always_comb begin
    evt_if.evt_valid  = ~fifo_empty;
    evt_if.evt_ts     = '0;
    evt_if.evt_period = '0;
    evt_if.evt_first  = 1'b0;
    if (!fifo_empty) begin
      evt_if.evt_ts     = ts_mem[rd_ptr_q];
      evt_if.evt_period = period_mem[rd_ptr_q];
      evt_if.evt_first  = first_mem[rd_ptr_q];
    end
  end

  assign evt_count_o  = evt_count_q;
  assign drop_count_o = drop_count_q;
  assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_tc_event_monitor.sv
// ---------------------------------------------------------------------------
// tb_tc_event_monitor
// Directed scenarios followed by a randomized phase, all checked against a
// queue-based reference model of the event monitor. A second instance with an
// 8-bit timer covers timestamp wrap-around.
// ---------------------------------------------------------------------------
module tb_tc_event_monitor;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] ts;
    logic [31:0] period;
    logic        first;
  } rec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic clr;
  logic tc;
  logic tc8;
  logic [15:0] evt_count;
  logic [7:0]  drop_count;
  logic        overflow;
  logic [15:0] evt_count8;
  logic [7:0]  drop_count8;
  logic        overflow8;

  tc_event_monitor_if #(.TS_WIDTH(32)) ev_if  ();
  tc_event_monitor_if #(.TS_WIDTH(8))  ev_if8 ();

  tc_event_monitor #(.TS_WIDTH(32), .DEPTH(DEPTH), .CNT_WIDTH(16)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .clear_i      (clr),
    .tc_i         (tc),
    .evt_if       (ev_if),
    .evt_count_o  (evt_count),
    .drop_count_o (drop_count),
    .overflow_o   (overflow)
  );

  tc_event_monitor #(.TS_WIDTH(8), .DEPTH(DEPTH), .CNT_WIDTH(16)) dut8 (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .clear_i      (1'b0),
    .tc_i         (tc8),
    .evt_if       (ev_if8),
    .evt_count_o  (evt_count8),
    .drop_count_o (drop_count8),
    .overflow_o   (overflow8)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int vcnt     = 0;

  // Reference model state: behaviour of the monitor as seen from outside.
  rec_t        mq[$];
  rec_t        obs_log[$];
  logic [31:0] m_timer;
  logic        m_tc_prev;
  logic [31:0] m_last;
  logic        m_first;
  logic [15:0] m_evt_cnt;
  int          m_drop;
  logic        m_ovf;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_timer   = '0;
    m_tc_prev = 1'b0;
    m_last    = '0;
    m_first   = 1'b1;
    m_evt_cnt = '0;
    m_drop    = 0;
    m_ovf     = 1'b0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit   edge_now;
    bit   was_full;
    rec_t r;
    edge_now = tc && !m_tc_prev;
    was_full = (mq.size() == DEPTH);
    if (clr) begin
      mq.delete();
      m_evt_cnt = '0;
      m_drop    = 0;
      m_ovf     = 1'b0;
      m_first   = 1'b1;
      m_last    = '0;
    end else begin
      if (mq.size() != 0 && ev_if.evt_ready) mq.delete(0);
      if (edge_now) begin
        m_evt_cnt = m_evt_cnt + 16'd1;
        if (!was_full) begin
          r.ts     = m_timer;
          r.period = m_first ? 32'd0 : (m_timer - m_last);
          r.first  = m_first;
          mq.push_back(r);
          m_last  = m_timer;
          m_first = 1'b0;
        end else begin
          m_ovf = 1'b1;
          if (m_drop < 255) m_drop++;
        end
      end
    end
    m_tc_prev = tc;
    m_timer   = m_timer + 32'd1;
  endtask

  task automatic check_all();
    chk("valid", ev_if.evt_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("head_ts",     ev_if.evt_ts,     mq[0].ts);
      chk("head_period", ev_if.evt_period, mq[0].period);
      chk("head_first",  ev_if.evt_first,  mq[0].first);
    end
    chk("evt_count",  evt_count,  m_evt_cnt);
    chk("drop_count", drop_count, m_drop[7:0]);
    chk("overflow",   overflow,   m_ovf);
    if (ev_if.evt_valid) vcnt++;
  endtask

  task automatic tick();
    rec_t r;
    if (ev_if.evt_valid && ev_if.evt_ready) begin
      r.ts = ev_if.evt_ts; r.period = ev_if.evt_period; r.first = ev_if.evt_first;
      obs_log.push_back(r);
      $display("EVT t=%0t ts=%0d period=%0d first=%0d", $time, r.ts, r.period, r.first);
    end
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic pulse();
    tc = 1'b1; tick();
    tc = 1'b0; tick();
  endtask

  task automatic wait_timer(input logic [31:0] t);
    for (int n = 0; n < 20000 && m_timer != t; n++) tick();
    if (m_timer != t) chk("wait_timer", m_timer, t);
  endtask

  task automatic wait_timer8(input logic [7:0] t);
    for (int n = 0; n < 600 && m_timer[7:0] != t; n++) tick();
    if (m_timer[7:0] != t) chk("wait_timer8", m_timer[7:0], t);
  endtask

  logic [31:0] t0;

  initial begin
    rst_n = 1'b0; clr = 1'b0; tc = 1'b0; tc8 = 1'b0;
    ev_if.evt_ready = 1'b0; ev_if8.evt_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", ev_if.evt_valid, 1'b0);
    chk("rst_ts", ev_if.evt_ts, 32'd0);
    chk("rst_count", evt_count, 16'd0);
    chk("rst_drop", drop_count, 8'd0);
    chk("rst_ovf", overflow, 1'b0);
    rst_n = 1'b1;
    model_reset();
    check_all();

    // Long-high tc_in at timer 10 yields one record
    ev_if.evt_ready = 1'b1;
    obs_log.delete();
    vcnt = 0;
    wait_timer(32'd10);
    tc = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 0) begin
        chk("t1_valid", ev_if.evt_valid, 1'b1);
        chk("t1_ts", ev_if.evt_ts, 32'd10);
        chk("t1_period", ev_if.evt_period, 32'd0);
        chk("t1_first", ev_if.evt_first, 1'b1);
        chk("t1_count", evt_count, 16'd1);
      end
    end
    tc = 1'b0;
    repeat (3) tick();
    chk("t1_valid_cycles", vcnt, 1);

    // Edges at 110 and 310: periods 0, 100, 200
    wait_timer(32'd110); pulse();
    wait_timer(32'd310); pulse();
    tick();
    chk("t2_nrec", obs_log.size(), 3);
    if (obs_log.size() == 3) begin
      chk("t2_ts1", obs_log[1].ts, 32'd110);
      chk("t2_ts2", obs_log[2].ts, 32'd310);
      chk("t2_p0", obs_log[0].period, 32'd0);
      chk("t2_p1", obs_log[1].period, 32'd100);
      chk("t2_p2", obs_log[2].period, 32'd200);
      chk("t2_f0", obs_log[0].first, 1'b1);
      chk("t2_f1", obs_log[1].first, 1'b0);
      chk("t2_f2", obs_log[2].first, 1'b0);
    end

    // 8-bit timer: edges at 250 and 4 after wrap
    wait_timer8(8'd250);
    tc8 = 1'b1; tick(); tc8 = 1'b0; tick();
    chk("w_valid", ev_if8.evt_valid, 1'b1);
    chk("w_ts0", ev_if8.evt_ts, 8'd250);
    chk("w_first0", ev_if8.evt_first, 1'b1);
    wait_timer8(8'd4);
    tc8 = 1'b1; tick(); tc8 = 1'b0;
    chk("w_head_stable", ev_if8.evt_ts, 8'd250);
    ev_if8.evt_ready = 1'b1; tick(); ev_if8.evt_ready = 1'b0;
    chk("w_ts1", ev_if8.evt_ts, 8'd4);
    chk("w_period1", ev_if8.evt_period, 8'd10);
    chk("w_first1", ev_if8.evt_first, 1'b0);
    chk("w_count", evt_count8, 16'd2);

    // Clear, then six edges with evt_ready low
    clr = 1'b1; tick(); clr = 1'b0;
    chk("clr_valid", ev_if.evt_valid, 1'b0);
    chk("clr_count", evt_count, 16'd0);
    ev_if.evt_ready = 1'b0;
    t0 = m_timer;
    for (int i = 0; i < 6; i++) begin
      pulse();
      chk("t3_head", ev_if.evt_ts, t0);
    end
    chk("t3_drop", drop_count, 8'd2);
    chk("t3_ovf", overflow, 1'b1);
    chk("t3_count", evt_count, 16'd6);
    obs_log.delete();
    ev_if.evt_ready = 1'b1;
    repeat (6) tick();
    chk("t3_nrec", obs_log.size(), 4);
    for (int i = 0; i < obs_log.size() && i < 4; i++)
      chk("t3_order", obs_log[i].ts, t0 + 32'(2 * i));

    // Full FIFO, edge and pop in the same cycle: edge dropped, 3 remain
    ev_if.evt_ready = 1'b0;
    repeat (4) pulse();
    tc = 1'b1; ev_if.evt_ready = 1'b1; tick();
    tc = 1'b0; ev_if.evt_ready = 1'b0; tick();
    chk("t5_drop", drop_count, 8'd3);
    obs_log.delete();
    ev_if.evt_ready = 1'b1;
    repeat (6) tick();
    chk("t5_nrec", obs_log.size(), 3);

    // Clear on an edge cycle with two records queued
    ev_if.evt_ready = 1'b0;
    repeat (2) pulse();
    tc = 1'b1; clr = 1'b1; tick();
    tc = 1'b0; clr = 1'b0;
    chk("t6_valid", ev_if.evt_valid, 1'b0);
    chk("t6_count", evt_count, 16'd0);
    chk("t6_drop", drop_count, 8'd0);
    chk("t6_ovf", overflow, 1'b0);
    tick();
    t0 = m_timer;
    pulse();
    chk("t6_first", ev_if.evt_first, 1'b1);
    chk("t6_period", ev_if.evt_period, 32'd0);
    chk("t6_ts", ev_if.evt_ts, t0);
    ev_if.evt_ready = 1'b1;
    repeat (2) tick();

    // Randomized phase
    for (int i = 0; i < 400; i++) begin
      tc  = ($urandom_range(0, 2) == 0);
      clr = ($urandom_range(0, 63) == 0);
      ev_if.evt_ready = (i < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
      tick();
    end
    clr = 1'b0; tc = 1'b0;
    ev_if.evt_ready = 1'b0;
    tick();

    // Asynchronous reset mid-drain
    repeat (3) pulse();
    ev_if.evt_ready = 1'b1;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", ev_if.evt_valid, 1'b0);
    chk("ar_ts", ev_if.evt_ts, 32'd0);
    chk("ar_period", ev_if.evt_period, 32'd0);
    chk("ar_first", ev_if.evt_first, 1'b0);
    chk("ar_count", evt_count, 16'd0);
    chk("ar_drop", drop_count, 8'd0);
    chk("ar_ovf", overflow, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_all();
    wait_timer(32'd5);
    tc = 1'b1; tick(); tc = 1'b0;
    chk("ar_ts_after", ev_if.evt_ts, 32'd5);
    chk("ar_first_after", ev_if.evt_first, 1'b1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
